// File: rtl/aes_pkg.sv
// Shared Rijndael ShiftRows helpers: row offsets, byte indexing, legal block sizes.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package aes_pkg;

    // Supported state widths in columns (128/192/256-bit blocks).
    localparam int NB_LEGAL [3] = '{4, 6, 8};

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    function automatic bit nb_is_legal(input int nb);
        return (nb == NB_LEGAL[0]) || (nb == NB_LEGAL[1]) || (nb == NB_LEGAL[2]);
    endfunction

    // Rijndael row offsets: the 256-bit block shifts rows 2 and 3 further.
    function automatic int row_shift(input int nb, input int r);
        if (nb == 8) begin
            case (r)
                0:       return 0;
                1:       return 1;
                2:       return 3;
                default: return 4;
            endcase
        end
        return r;
    endfunction

    // Bytes are packed column-major: four rows per column.
    function automatic int byte_idx(input int c, input int r);
        return 4 * c + r;
    endfunction

    // Source column feeding output column c of row r. Offsets never exceed
    // nb, so adding nb keeps the inverse case non-negative before the mod.
    function automatic int src_col(input int nb, input int c, input int r, input bit inv);
        if (inv)
            return (c - row_shift(nb, r) + nb) % nb;
        return (c + row_shift(nb, r)) % nb;
    endfunction

endpackage

// File: rtl/shiftrow_net.sv
// Combinational ShiftRows / InvShiftRows byte permutation (pure wiring plus optional mux).
// Latency: 0 cycles.
// Backpressure: none, purely combinational.
// Ports: state (in, 32*NB bits), inv (in, inverse select), shifted (out, 32*NB bits).
// Macro SHIFTROW_INV_EN: when defined, inv selects the inverse permutation;
// otherwise only the forward permutation is built and inv is ignored.
module shiftrow_net
    import aes_pkg::*;
#(
    parameter int NB = 4
)
(
    input  logic [0:32*NB-1] state,
    input  logic             inv,
    output logic [0:32*NB-1] shifted
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = byte_idx(c, r);
            localparam int FWD = byte_idx(src_col(NB, c, r, 1'b0), r);
`ifdef SHIFTROW_INV_EN
            localparam int INV = byte_idx(src_col(NB, c, r, 1'b1), r);
            assign shifted[8*DST +: 8] = inv ? state[8*INV +: 8] : state[8*FWD +: 8];
`else
            assign shifted[8*DST +: 8] = state[8*FWD +: 8];
`endif
        end
    end

`ifndef SHIFTROW_INV_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

endmodule

// File: rtl/shiftrow_pipe.sv
// Valid/ready ShiftRows stage: permutes on input, stores result in a 2-entry skid FIFO.
// Latency: 1 cycle from accept to out_valid when empty; one beat/cycle sustained.
// Backpressure: in_ready is registered (occupancy < 2), never combinational on out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_inv/in_state upstream;
//        out_valid/out_ready/out_state/out_inv downstream; beat_cnt = output transfers (wraps).
// Macro SHIFTROW_INV_EN: enables in_inv-selected InvShiftRows; otherwise forward only, out_inv = 0.
module shiftrow_pipe
    import aes_pkg::*;
#(
    parameter int NB = 4,
    parameter int W  = 32 * NB
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [0:W-1] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] out_state,
    output logic         out_inv,
    output logic [15:0]  beat_cnt
);

    if (!nb_is_legal(NB) || (W != 32 * NB)) begin : g_param_check
        $error("shiftrow_pipe: NB must be 4, 6 or 8 and W must equal 32*NB");
    end

    logic         inv_sel;
    logic [0:W-1] shifted;

`ifdef SHIFTROW_INV_EN
    assign inv_sel = in_inv;
`else
    assign inv_sel = 1'b0;
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    shiftrow_net #(.NB(NB)) u_net (
        .state   (in_state),
        .inv     (inv_sel),
        .shifted (shifted)
    );

    // out_state/out_inv is the FIFO head; skid_* holds the second entry.
    occ_t         occ;
    occ_t         occ_nxt;
    logic [0:W-1] skid_state;
    logic         skid_inv;
    logic         accept;
    logic         consume;

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    always_comb begin
        occ_nxt = occ;
        unique case (occ)
            OCC_EMPTY: if (accept)                 occ_nxt = OCC_ONE;
            OCC_ONE:   if (accept && !consume)     occ_nxt = OCC_TWO;
                       else if (!accept && consume) occ_nxt = OCC_EMPTY;
            OCC_TWO:   if (consume)                occ_nxt = OCC_ONE;
            default:                               occ_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= OCC_EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_inv    <= 1'b0;
            skid_state <= '0;
            skid_inv   <= 1'b0;
            beat_cnt   <= 16'd0;
        end else begin
            occ       <= occ_nxt;
            // Flags come straight off the next-occupancy decode so they are
            // flops; in_ready also rises on the first edge out of reset.
            in_ready  <= (occ_nxt != OCC_TWO);
            out_valid <= (occ_nxt != OCC_EMPTY);
            if (consume)
                beat_cnt <= beat_cnt + 16'd1;
            unique case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_state <= shifted;
                        out_inv   <= inv_sel;
                    end
                end
                OCC_ONE: begin
                    if (accept && consume) begin
                        out_state <= shifted;
                        out_inv   <= inv_sel;
                    end else if (accept) begin
                        skid_state <= shifted;
                        skid_inv   <= inv_sel;
                    end
                end
                OCC_TWO: begin
                    if (consume) begin
                        out_state <= skid_state;
                        out_inv   <= skid_inv;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shiftrow_pipe.sv
// Self-checking bench for shiftrow_pipe: scoreboard model with randomized traffic plus known answers.
// Latency: n/a.
// Backpressure: out_ready driven randomly and held low for fill tests.
module tb_shiftrow_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic [0:127] in_state = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:127] out_state;
    logic         out_inv;
    logic [15:0]  beat_cnt;

    logic         in8_valid = 1'b0;
    logic         in8_inv = 1'b0;
    logic [0:255] in8_state = '0;
    logic         in8_ready;
    logic         out8_valid;
    logic         out8_ready = 1'b0;
    logic [0:255] out8_state;
    logic         out8_inv;
    logic [15:0]  cnt8;

    shiftrow_pipe #(.NB(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_inv(out_inv), .beat_cnt(beat_cnt)
    );

    shiftrow_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready), .in_inv(in8_inv),
        .in_state(in8_state), .out_valid(out8_valid), .out_ready(out8_ready),
        .out_state(out8_state), .out_inv(out8_inv), .beat_cnt(cnt8)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [0:127] st;
        logic         inv;
    } beat_t;

    beat_t       q[$];
    int unsigned n_done = 0;
    bit          armed = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ShiftRows from the textbook rule: row r rotates left by r columns.
    function automatic logic [0:127] mdl(input logic [0:127] s, input logic iv);
        logic [0:127] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (iv) src = (c - r + 4) % 4;
                else    src = (c + r) % 4;
                o[8*(4*c+r) +: 8] = s[8*(4*src+r) +: 8];
            end
        end
        return o;
    endfunction

    // One clock: drive at negedge, check outputs 1ns later, advance the model
    // for the handshake that the next rising edge will perform.
    task automatic step(input logic r, input logic v, input logic iv, input logic [0:127] d,
                        input logic ordy, output logic acc);
        beat_t b;
        logic  con;
        @(negedge clk);
        rst = r; in_valid = v; in_inv = iv; in_state = d; out_ready = ordy;
        #1;
        acc = 1'b0;
        if (r) begin
            q.delete();
            n_done = 0;
            armed  = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_state", out_state, 0);
            chk("rst_out_inv", out_inv, 0);
            chk("rst_beat_cnt", beat_cnt, 0);
        end else begin
            chk("in_ready", in_ready, armed && (q.size() < 2));
            chk("out_valid", out_valid, q.size() > 0);
            chk("beat_cnt", beat_cnt, n_done[15:0]);
            if (q.size() > 0) begin
                chk("out_state", out_state, q[0].st);
                chk("out_inv", out_inv, q[0].inv);
            end
            acc = v && armed && (q.size() < 2);
            con = ordy && (q.size() > 0);
            if (con) begin
                void'(q.pop_front());
                n_done++;
            end
            if (acc) begin
`ifdef SHIFTROW_INV_EN
                b.inv = iv;
`else
                b.inv = 1'b0;
`endif
                b.st = mdl(d, b.inv);
                q.push_back(b);
            end
            armed = 1'b1;
        end
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         acc;
        logic [0:127] kat_in;
        logic [0:127] kat_out;
        logic [0:127] pend;
        logic [0:255] d8;
        int           guard;

        kat_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
        kat_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

        // Reset, then the first sample after release must still show in_ready low.
        step(1, 0, 0, '0, 0, acc);
        step(1, 0, 0, '0, 0, acc);
        step(0, 0, 0, '0, 0, acc);
        chk("in_ready_first_cycle", in_ready, 0);

        // Known-answer forward shift.
        chk("model_kat_fwd", mdl(kat_in, 1'b0), kat_out);
        chk("model_kat_inv", mdl(kat_out, 1'b1), kat_in);
        step(0, 1, 0, kat_in, 0, acc);
        step(0, 0, 0, '0, 0, acc);
        chk("kat_fwd_state", out_state, kat_out);
        chk("kat_fwd_inv", out_inv, 0);
        step(0, 0, 0, '0, 1, acc);

        // Inverse beat: shifts back when enabled, forward with out_inv 0 otherwise.
        step(0, 1, 1, kat_out, 0, acc);
        step(0, 0, 0, '0, 0, acc);
`ifdef SHIFTROW_INV_EN
        chk("kat_inv_state", out_state, kat_in);
        chk("kat_inv_flag", out_inv, 1);
`else
        chk("noinv_flag", out_inv, 0);
        chk("noinv_state_ne_inverse", out_state == kat_in, 0);
`endif
        step(0, 0, 0, '0, 1, acc);
        step(0, 0, 0, '0, 0, acc);

        // 256-bit block: bytes 00..1f ascending.
        @(negedge clk);
        for (int k = 0; k < 32; k++) d8[8*k +: 8] = k[7:0];
        in8_state = d8;
        in8_valid = 1'b1;
        #1;
        chk("nb8_in_ready", in8_ready, 1);
        @(negedge clk);
        in8_valid = 1'b0;
        #1;
        chk("nb8_out_valid", out8_valid, 1);
        chk("nb8_r0c0", out8_state[0 +: 8], 8'h00);
        chk("nb8_r1c0", out8_state[8 +: 8], 8'h05);
        chk("nb8_r2c0", out8_state[16 +: 8], 8'h0e);
        chk("nb8_r3c0", out8_state[24 +: 8], 8'h13);
        chk("nb8_r3c7", out8_state[248 +: 8], 8'h0f);
        chk("nb8_out_inv", out8_inv, 0);

        // Backpressure: three offers with out_ready low, only two fit.
        step(0, 1, 0, rnd128(), 0, acc);
        step(0, 1, 0, rnd128(), 0, acc);
        pend = rnd128();
        step(0, 1, 0, pend, 0, acc);
        chk("bp_in_ready_full", in_ready, 0);
        chk("bp_out_valid_full", out_valid, 1);
        step(0, 1, 0, pend, 0, acc);
        chk("bp_still_full", in_ready, 0);
        guard = 0;
        do begin
            step(0, 1, 0, pend, 1, acc);
            guard++;
        end while (!acc && guard < 5);
        chk("bp_third_accepted", acc, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, acc);
        chk("bp_drained", out_valid, 0);

        // Randomized traffic, 1000 output transfers from a fresh reset.
        step(1, 0, 0, '0, 0, acc);
        step(0, 0, 0, '0, 0, acc);
        pend  = rnd128();
        guard = 0;
        while (n_done < 1000 && guard < 20000) begin
            logic v, iv, ordy;
            v    = ($urandom_range(0, 3) != 0);
            iv   = $urandom_range(0, 1);
            ordy = $urandom_range(0, 1);
            step(0, v, iv, pend, ordy, acc);
            if (acc) pend = rnd128();
            guard++;
        end
        chk("rand_done_in_budget", n_done, 1000);
        step(0, 0, 0, '0, 0, acc);
        chk("beat_cnt_1000", beat_cnt, 16'd1000);

        // Full-throughput stream up to the counter wrap.
        guard = 0;
        while (n_done < 65534 && guard < 70000) begin
            step(0, 1, 0, rnd128(), 1, acc);
            guard++;
        end
        step(0, 1, 0, rnd128(), 0, acc);
        chk("beat_cnt_fffe", beat_cnt, 16'hfffe);
        chk("wrap_two_queued", out_valid, 1);
        step(0, 0, 0, '0, 1, acc);
        step(0, 0, 0, '0, 1, acc);
        step(0, 0, 0, '0, 0, acc);
        chk("beat_cnt_wrap", beat_cnt, 16'h0000);
        chk("wrap_empty", out_valid, 0);

        // Asynchronous reset while two beats are buffered.
        for (int i = 0; i < 3; i++) step(0, 1, 0, rnd128(), 1, acc);
        for (int i = 0; i < 3; i++) step(0, 1, 0, rnd128(), 0, acc);
        chk("arst_pre_full", in_ready, 0);
        chk("arst_pre_cnt", beat_cnt, 16'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_beat_cnt", beat_cnt, 0);
        chk("arst_in_ready", in_ready, 0);
        step(1, 0, 0, '0, 1, acc);
        step(1, 0, 0, '0, 1, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, acc);
        chk("arst_no_stale", out_valid, 0);
        step(0, 1, 0, kat_in, 0, acc);
        step(0, 0, 0, '0, 0, acc);
        chk("arst_after_kat", out_state, kat_out);
        step(0, 0, 0, '0, 1, acc);
        step(0, 0, 0, '0, 0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftrow_pipe.md
SHIFTROW_PIPE -- requirements
Module: shiftrow_pipe

Interface
REQ-001 Parameter NB, default 4, meaning number of state columns; legal values 4, 6, 8 (Rijndael block sizes 128/192/256).
REQ-002 Parameter W, default 32*NB, meaning state width in bits; W SHALL equal 32*NB (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the beat.
REQ-008 in_state  input  [0:W-1]  state in; byte k = bits [8k:8k+7], column c = k/4, row r = k%4.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts.
REQ-011 out_state  output  [0:W-1]  shifted state, same byte layout.
REQ-012 out_inv  output  1  in_inv carried with the beat.
REQ-013 beat_cnt  output  16  count of completed output transfers.

Function
REQ-014 Row offsets s(r): NB=4 or 6 -> 0,1,2,3; NB=8 -> 0,1,3,4.
REQ-015 Forward: out byte (c,r) = in byte ((c + s(r)) mod NB, r); inverse: in byte ((c - s(r)) mod NB, r), with mod always non-negative.
REQ-016 Transfer rule: input beat accepted iff in_valid && in_ready; output beat consumed iff out_valid && out_ready.
REQ-017 Storage is a 2-entry FIFO (skid buffer) holding shifted result plus inv bit; shift is applied before storage.
REQ-018 Latency: accepted beat appears on out_* the next cycle when the FIFO was empty; order strictly preserved.
REQ-019 in_ready = 1 when occupancy < 2; it depends only on registered state, never combinationally on out_ready.
REQ-020 out_valid = 1 when occupancy > 0; out_state/out_inv SHALL stay stable while out_valid && !out_ready.
REQ-021 Simultaneous accept and consume at occupancy 1 or 2: occupancy unchanged, full throughput of one beat per cycle sustained.
REQ-022 Full (occupancy 2): in_ready = 0, in_valid ignored, no data overwritten.
REQ-023 Empty: out_valid = 0; out_state holds last value (not required to be zero after first beat).
REQ-024 beat_cnt increments on each output transfer and wraps 16'hFFFF -> 16'h0000.
REQ-025 Occupancy state machine: EMPTY -> ONE on accept; ONE -> TWO on accept without consume; ONE -> EMPTY on consume without accept; TWO -> ONE on consume; all other combinations hold.

Reset
REQ-026 While rst is high: occupancy EMPTY, out_valid 0, in_ready 0, out_state all zero, out_inv 0, beat_cnt 0.
REQ-027 in_ready rises the first clock edge after rst deasserts; a reset mid-operation discards all buffered beats with no partial output.

Configuration
REQ-028 Macro SHIFTROW_INV_EN: when defined, in_inv selects inverse per REQ-015.
REQ-029 Without SHIFTROW_INV_EN: in_inv port still exists but is ignored, forward shift only, out_inv always 0; inverse mux logic is absent.

Structure
REQ-030 Shared package aes_pkg holds NB-dependent offset function s(r), the byte-index helper, and the legal-NB constant list.
REQ-031 One combinational sub-module shiftrow_net (parameter NB, inputs state and inv, output shifted state) performs the byte permutation; shiftrow_pipe instantiates it once at the input side.

Verification
REQ-032 NB=4, forward, in_state d42711aee0bf98f1b8b45de51e415230 -> out_state d4bf5d30e0b452aeb84111f11e2798e5 one cycle after accept.
REQ-033 NB=4, SHIFTROW_INV_EN, inv=1, in d4bf5d30e0b452aeb84111f11e2798e5 -> out d42711aee0bf98f1b8b45de51e415230, out_inv 1.
REQ-034 NB=8, forward, bytes 00..1f ascending -> row 2 column 0 byte = 0e (from column 3), row 3 column 0 byte = 13 (from column 4).
REQ-035 out_ready held 0, three beats offered -> exactly two accepted, in_ready 0 after second; release -> both delivered in order, third then accepted.
REQ-036 Back-to-back 1000 beats with out_ready toggled pseudo-randomly -> no loss or reorder, beat_cnt = 1000 (preset 16'hFFFE then two transfers -> 16'h0000).
REQ-037 Assert rst while occupancy 2 -> out_valid 0 immediately (asynchronous), beat_cnt 0, no stale beat after release.
